sram_rd_seq: RTL

- Read-sequence generator for the global buffer.
- Walks `data_num` entries striped round-robin across `sram_num` SRAM banks and emits one (bank ID, row address) per handshake.
- Repeats the walk `cyc_num` passes, supports pull-back (rewind of the current pass), and raises `done` once the last pass is issued and the SRAM side reports completion.
- Successor of the fixed 4-bit bank-ID counter: parametrised widths, valid/ready output, row address, config checking.

---
 rtl/sram_rd_pkg.sv | 11 +
 rtl/sram_rd_seq_if.sv | 15 +
 rtl/sram_bank_row_ctr.sv | 57 +++++
 rtl/sram_rd_seq.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sram_rd_pkg.sv
// sram_rd_pkg: shared state encoding, default widths and config-legality check for sram_rd_seq
package sram_rd_pkg;
  localparam int ID_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int CYC_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, WAIT_DONE} state_e;
  function automatic logic cfg_legal(input logic [31:0] sram_num, data_num, cyc_num, input int id_w);
    return sram_num != '0 && sram_num <= (32'd1 << id_w) && data_num != '0 && cyc_num != '0;
  endfunction
endpackage

// File: rtl/sram_rd_seq_if.sv
// sram_rd_seq_if: valid/ready read-request channel carrying bank ID, row address, last flag and pass index
interface sram_rd_seq_if #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 8,
  parameter int CYC_W = 8
);
  logic rd_valid;
  logic rd_ready;
  logic [ID_W-1:0] rd_id;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_last;
  logic [CYC_W-1:0] rd_pass;
  modport master(output rd_valid, rd_id, rd_addr, rd_last, rd_pass, input rd_ready);
  modport slave(input rd_valid, rd_id, rd_addr, rd_last, rd_pass, output rd_ready);
endinterface

// File: rtl/sram_bank_row_ctr.sv
// sram_bank_row_ctr: divider-free bank/row/idx walker with inc, dec, pass-start snapshot save/load and clear
module sram_bank_row_ctr #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              save,
  input  logic              inc,
  input  logic              dec,
  input  logic [ID_W:0]     sram_num,
  output logic [ID_W-1:0]   bank,
  output logic [ADDR_W-1:0] row,
  output logic [CNT_W-1:0]  idx
);
  logic [ID_W-1:0] bank_q, bank_d, sbank_q, sbank_d;
  logic [ADDR_W-1:0] row_q, row_d, srow_q, srow_d;
  logic [CNT_W-1:0] idx_q, idx_d, sidx_q, sidx_d;
  logic [ID_W:0] sm1;
  logic wrap_up, wrap_dn;
  always_comb begin
    sm1 = sram_num - 1'b1;
    wrap_up = {1'b0, bank_q} == sm1;
    wrap_dn = bank_q == '0;
    bank_d = clr ? '0 : load ? sbank_q : inc ? (wrap_up ? '0 : bank_q + 1'b1) :
             dec ? (wrap_dn ? sm1[ID_W-1:0] : bank_q - 1'b1) : bank_q;
    row_d = clr ? '0 : load ? srow_q : (inc && wrap_up) ? row_q + 1'b1 :
            (dec && wrap_dn) ? row_q - 1'b1 : row_q;
    idx_d = clr ? '0 : load ? sidx_q : inc ? idx_q + 1'b1 : dec ? idx_q - 1'b1 : idx_q;
    sbank_d = clr ? '0 : save ? bank_q : sbank_q;
    srow_d = clr ? '0 : save ? row_q : srow_q;
    sidx_d = clr ? '0 : save ? idx_q : sidx_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q <= '0;
      row_q <= '0;
      idx_q <= '0;
      sbank_q <= '0;
      srow_q <= '0;
      sidx_q <= '0;
    end else begin
      bank_q <= bank_d;
      row_q <= row_d;
      idx_q <= idx_d;
      sbank_q <= sbank_d;
      srow_q <= srow_d;
      sidx_q <= sidx_d;
    end
  end
  assign bank = bank_q;
  assign row = row_q;
  assign idx = idx_q;
endmodule

// File: rtl/sram_rd_seq.sv
// sram_rd_seq: multi-pass round-robin bank/row read sequencer with pull-back and done handshake
// SRAM_RD_SERPENTINE_EN: odd passes walk descending; a pass then starts where the previous one ended.
module sram_rd_seq
  import sram_rd_pkg::*;
#(
  parameter int ID_W = ID_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ID_W:0]     sram_num,
  input  logic [CNT_W-1:0]  data_num,
  input  logic [CYC_W-1:0]  cyc_num,
  input  logic              pull_back,
  input  logic              read_sram_done,
  sram_rd_seq_if.master     rd,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
`ifdef SRAM_RD_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif
  state_e state_q, state_d;
  logic [ID_W:0] sram_num_q, sram_num_d;
  logic [CNT_W-1:0] data_num_q, data_num_d;
  logic [CYC_W-1:0] cyc_num_q, cyc_num_d, pass_q, pass_d;
  logic done_q, done_d, cfg_err_q, cfg_err_d;
  logic clr, load, save, inc, dec, run, desc, last;
  logic [ID_W-1:0] bank;
  logic [ADDR_W-1:0] row;
  logic [CNT_W-1:0] idx;
  sram_bank_row_ctr #(.ID_W(ID_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ctr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .save(save), .inc(inc), .dec(dec),
    .sram_num(sram_num_q), .bank(bank), .row(row), .idx(idx)
  );
  always_comb begin
    run = state_q == RUN;
    desc = SERP && pass_q[0];
    last = desc ? idx == '0 : idx == data_num_q - 1'b1;
    state_d = state_q;
    sram_num_d = sram_num_q;
    data_num_d = data_num_q;
    cyc_num_d = cyc_num_q;
    pass_d = pass_q;
    done_d = 1'b0;
    cfg_err_d = 1'b0;
    clr = 1'b0;
    load = 1'b0;
    save = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    if (start) begin
      if (cfg_legal(32'(sram_num), 32'(data_num), 32'(cyc_num), ID_W)) begin
        state_d = RUN;
        sram_num_d = sram_num;
        data_num_d = data_num;
        cyc_num_d = cyc_num;
        pass_d = '0;
        clr = 1'b1;
      end else begin
        state_d = IDLE;
        cfg_err_d = 1'b1;
      end
    end else if (run) begin
      if (pull_back) load = 1'b1;
      else if (rd.rd_ready) begin
        if (!last) begin
          inc = !desc;
          dec = desc;
        end else if (pass_q == cyc_num_q - 1'b1) state_d = WAIT_DONE;
        else begin
          pass_d = pass_q + 1'b1;
          // serpentine turns around in place, so the end position becomes the new pass start
          clr = !SERP;
          save = SERP;
        end
      end
    end else if (state_q == WAIT_DONE) begin
      if (pull_back) begin
        state_d = RUN;
        load = 1'b1;
      end else if (read_sram_done) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sram_num_q <= '0;
      data_num_q <= '0;
      cyc_num_q <= '0;
      pass_q <= '0;
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sram_num_q <= sram_num_d;
      data_num_q <= data_num_d;
      cyc_num_q <= cyc_num_d;
      pass_q <= pass_d;
      done_q <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign rd.rd_valid = run;
  assign rd.rd_id = bank;
  assign rd.rd_addr = row;
  assign rd.rd_last = run & last;
  assign rd.rd_pass = pass_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign cfg_err = cfg_err_q;
endmodule
